matrix_line_driver: RTL

- Consumes the 3-bit demux channel code produced by the 1-of-8 selector and drives the 8 matrix select lines.
- Each line is driven one-hot, with a fixed blanking gap before every new line and a minimum on-time (dwell) per line.
- Has a one-entry pending buffer, so the selector side can queue the next code while the current line is still lit.
- Sits between the selector logic and the physical row/column pins of the display matrix.

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/line_onehot_decoder.sv | 22 ++
 rtl/matrix_line_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix line driver slice.
// Provides the controller state type, line/code widths, and the
// all-lines-inactive pattern for a given output polarity.
package matrix_pkg;

  localparam int LINE_COUNT = 8;
  localparam int CODE_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } line_state_e;

  // Pattern with every select line deasserted at the given polarity.
  function automatic logic [LINE_COUNT-1:0] inactive_pattern(input logic active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/line_onehot_decoder.sv
// Combinational 1-of-8 line select decoder.
// Ports:
//   code       - channel code 0..7
//   active_low - 1: selected line is 0 and the rest 1; 0: opposite polarity
//   lines      - decoded select lines, bit n active when code == n
module line_onehot_decoder
  import matrix_pkg::*;
(
  input  logic [CODE_W-1:0]     code,
  input  logic                  active_low,
  output logic [LINE_COUNT-1:0] lines
);

  logic [LINE_COUNT-1:0] onehot;

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
    lines        = active_low ? ~onehot : onehot;
  end

endmodule

// File: rtl/matrix_line_driver.sv
// Matrix line driver: takes channel codes from the selector through a
// valid/ready handshake into a one-entry pending buffer, then drives the
// 8 matrix select lines one-hot with a blanking gap before every new line
// and a minimum dwell time per line.
// Ports:
//   clk, rst           - clock (rising edge), async active-high reset
//   sel_valid/sel_code - incoming channel code and its qualifier
//   sel_ready          - code can be accepted this cycle
//   sel_clear          - synchronous blank-and-return-to-idle request
//   dmx_out            - registered line selects
//   code_q             - code currently (or last) driven
//   busy               - high while blanking or driving
module matrix_line_driver
  import matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_valid,
  input  logic [CODE_W-1:0]     sel_code,
  output logic                  sel_ready,
  input  logic                  sel_clear,
  output logic [LINE_COUNT-1:0] dmx_out,
  output logic [CODE_W-1:0]     code_q,
  output logic                  busy
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [LINE_COUNT-1:0] LINES_OFF = inactive_pattern(ACTIVE_LOW);

  line_state_e           state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [CODE_W-1:0]     pend_code_q, pend_code_d;
  logic [CODE_W-1:0]     code_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_COUNT-1:0] dmx_q, dmx_d;
  logic [LINE_COUNT-1:0] drive_lines;
  logic                  accept;

  // No bypass: a code always lands in the pending register first.
  assign sel_ready = !pend_valid_q && !sel_clear;
  assign accept    = sel_valid && sel_ready;
  assign busy      = (state_q != IDLE);
  assign dmx_out   = dmx_q;

  // Decode from the next code so the output flop carries the new line
  // on the same edge the state enters DRIVE.
  line_onehot_decoder u_decoder (
    .code       (code_d),
    .active_low (ACTIVE_LOW),
    .lines      (drive_lines)
  );

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    code_d       = code_q;
    cnt_d        = cnt_q;

    if (sel_clear) begin
      state_d      = IDLE;
      pend_valid_d = 1'b0;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            code_d       = pend_code_q;
            pend_valid_d = 1'b0;
            cnt_d        = BLANK_LOAD;
            state_d      = BLANK;
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            cnt_d   = DWELL_LOAD;
            state_d = DRIVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (pend_valid_q) begin
            code_d       = pend_code_q;
            pend_valid_d = 1'b0;
            cnt_d        = BLANK_LOAD;
            state_d      = BLANK;
          end
        end
        default: state_d = IDLE;
      endcase

      // accept implies pend_valid_q == 0, so it never races a consume.
      if (accept) begin
        pend_valid_d = 1'b1;
        pend_code_d  = sel_code;
      end
    end

    dmx_d = (state_d == DRIVE) ? drive_lines : LINES_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      code_q       <= '0;
      cnt_q        <= '0;
      dmx_q        <= LINES_OFF;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      dmx_q        <= dmx_d;
    end
  end

endmodule
